uart_prog_loader: RTL and testbench

Receives the program image sent serially over the user-project UART pin (mprj_io[5]) and writes it as 32-bit words into the core's instruction memory port. It sits directly downstream of the bench-side UART programmer and upstream of the BrqRV_EB1 instruction memory. It holds the core in reset until an end-of-program marker word arrives. It drives the ready indication (mprj_io[37]) that the programmer waits for before sending.

---
 rtl/uart_prog_loader.sv | 215 +++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// Receives an 8N1 UART byte stream, assembles little-endian 32-bit words and writes them to instruction memory.
// Write strobe follows the 4th byte's stop-bit sample by 2 cycles (plus 2 synchroniser cycles); no backpressure on rx_i.
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 347,
    parameter int          ADDR_W       = 13,
    parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              rx_i,
    output logic              ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_rst_o,
    output logic              prog_done_o,
    output logic              frame_err_o,
    output logic              ovf_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_CLEANUP
    } rx_state_t;

    typedef enum logic {
        LD_LOAD,
        LD_DONE
    } ld_state_t;

    logic             r_rx_meta;
    logic             r_rxs;
    rx_state_t        r_rx_state;
    rx_state_t        w_rx_next;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_rx_byte;
    logic             r_byte_vld;
    logic             r_frame_err;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_bit_smp;
    logic             w_stop_smp;

    ld_state_t        r_ld_state;
    ld_state_t        w_ld_next;
    logic [31:0]      r_word;
    logic [1:0]       r_bcnt;
    logic [ADDR_W:0]  r_addr;
    logic             r_ready;
    logic             r_we;
    logic [ADDR_W-1:0] r_maddr;
    logic [31:0]      r_wdata;
    logic             r_core_rst;
    logic             r_done;
    logic             r_ovf;
    logic             w_take;
    logic             w_word_last;
    logic [31:0]      w_word;
    logic             w_is_end;
    logic             w_full;

    // Two-flop synchroniser, idles high like the line itself
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rxs     <= r_rx_meta;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_rx_state <= RX_IDLE;
        else          r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next  = r_rx_state;
        w_cnt_clr  = 1'b0;
        w_cnt_inc  = 1'b0;
        w_bit_smp  = 1'b0;
        w_stop_smp = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!r_rxs) w_rx_next = RX_START;
            end
            RX_START: begin
                // Re-check the line at mid start bit to reject glitches
                if (r_clk_cnt == HALF_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_rx_next = r_rxs ? RX_IDLE : RX_DATA;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            RX_DATA: begin
                if (r_clk_cnt == BIT_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_bit_smp = 1'b1;
                    if (r_bit_idx == 3'd7) w_rx_next = RX_STOP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            RX_STOP: begin
                if (r_clk_cnt == BIT_LAST) begin
                    w_cnt_clr  = 1'b1;
                    w_stop_smp = 1'b1;
                    w_rx_next  = RX_CLEANUP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            RX_CLEANUP: begin
                w_cnt_clr = 1'b1;
                w_rx_next = RX_IDLE;
            end
            default: begin
                w_cnt_clr = 1'b1;
                w_rx_next = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_rx_byte   <= '0;
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_cnt_clr)      r_clk_cnt <= '0;
            else if (w_cnt_inc) r_clk_cnt <= r_clk_cnt + 1'b1;
            if (w_bit_smp) begin
                r_rx_byte[r_bit_idx] <= r_rxs;
                r_bit_idx            <= r_bit_idx + 3'd1;
            end
            r_byte_vld <= w_stop_smp & r_rxs;
            if (w_stop_smp && !r_rxs) r_frame_err <= 1'b1;
        end
    end

    // New bytes enter at the top so the first byte ends up in bits [7:0]
    assign w_take      = r_byte_vld && (r_ld_state == LD_LOAD);
    assign w_word      = {r_rx_byte, r_word[31:8]};
    assign w_word_last = w_take && (r_bcnt == 2'd3);
    assign w_is_end    = (w_word == END_WORD);
    assign w_full      = r_addr[ADDR_W];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_ld_state <= LD_LOAD;
        else          r_ld_state <= w_ld_next;
    end

    always_comb begin
        w_ld_next = r_ld_state;
        if (r_ld_state == LD_LOAD && w_word_last && w_is_end) w_ld_next = LD_DONE;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_word     <= '0;
            r_bcnt     <= '0;
            r_addr     <= '0;
            r_ready    <= 1'b0;
            r_we       <= 1'b0;
            r_maddr    <= '0;
            r_wdata    <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_we    <= 1'b0;
            if (w_take) begin
                r_word <= w_word;
                r_bcnt <= r_bcnt + 2'd1;
            end
            if (w_word_last) begin
                if (w_is_end) begin
                    r_done     <= 1'b1;
                    r_core_rst <= 1'b0;
                end else if (!w_full) begin
                    r_we    <= 1'b1;
                    r_wdata <= w_word;
                    r_maddr <= r_addr[ADDR_W-1:0];
                    r_addr  <= r_addr + 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    assign ready_o     = r_ready;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_maddr;
    assign mem_wdata_o = r_wdata;
    assign core_rst_o  = r_core_rst;
    assign prog_done_o = r_done;
    assign frame_err_o = r_frame_err;
    assign ovf_err_o   = r_ovf;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomised bench for uart_prog_loader: a byte-stream reference model predicts every memory write and flag.
module tb_uart_prog_loader;

    localparam int          CPB  = 4;
    localparam int          AW   = 4;
    localparam logic [31:0] ENDW = 32'h0000_0FFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          ready, we, core_rst, done, ferr, ovf;
    logic [AW-1:0] maddr;
    logic [31:0]   wdata;

    always #5 clk = ~clk;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .END_WORD(ENDW)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .rx_i        (rx),
        .ready_o     (ready),
        .mem_we_o    (we),
        .mem_addr_o  (maddr),
        .mem_wdata_o (wdata),
        .core_rst_o  (core_rst),
        .prog_done_o (done),
        .frame_err_o (ferr),
        .ovf_err_o   (ovf)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference model: operates on whole bytes and words, not on bit timing
    logic [7:0]  m_bytes[$];
    logic [31:0] q_data[$];
    logic [31:0] q_addr[$];
    bit          m_done, m_ferr, m_ovf;
    int          m_nwr;

    function automatic void model_reset();
        m_bytes.delete();
        q_data.delete();
        q_addr.delete();
        m_done = 0;
        m_ferr = 0;
        m_ovf  = 0;
        m_nwr  = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit good);
        logic [31:0] w;
        if (!good) begin
            m_ferr = 1;
            return;
        end
        if (m_done) return;
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
            w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            m_bytes.delete();
            if (w == ENDW) m_done = 1;
            else if (m_nwr < (1 << AW)) begin
                q_addr.push_back(32'(m_nwr));
                q_data.push_back(w);
                m_nwr++;
            end else m_ovf = 1;
        end
    endfunction

    int          n_wr = 0;
    bit          watch = 0;
    bit          rst_dropped = 0;
    logic [31:0] e_a, e_d;

    always @(negedge clk) begin
        if (we) begin
            n_wr++;
            check("wr_expected", 32'(q_addr.size() != 0), 1);
            if (q_addr.size() != 0) begin
                e_a = q_addr.pop_front();
                e_d = q_data.pop_front();
                check("wr_addr", 32'(maddr), e_a);
                check("wr_data", wdata, e_d);
            end
        end
        if (watch && core_rst !== 1'b1) rst_dropped = 1;
    end

    task automatic send_byte(input logic [7:0] b, input bit good);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = good;
        model_byte(b, good);
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB * $urandom_range(2, 4)) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        do w = $urandom(); while (w == ENDW);
        return w;
    endfunction

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: time limit reached, total=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    int snap;

    initial begin
        model_reset();
        @(negedge clk);
        check("rst_core_rst", 32'(core_rst), 1);
        check("rst_ready", 32'(ready), 0);
        check("rst_we", 32'(we), 0);
        check("rst_addr", 32'(maddr), 0);
        check("rst_wdata", wdata, 0);
        check("rst_done", 32'(done), 0);
        check("rst_ferr", 32'(ferr), 0);
        check("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rel", 32'(ready), 1);
        check("core_held", 32'(core_rst), 1);
        @(negedge clk);

        // Normal load
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        send_word(ENDW);
        check("norm_done", 32'(done), 1);
        check("norm_core_rst", 32'(core_rst), 0);
        check("norm_nwr", 32'(n_wr), 2);
        check("norm_pending", 32'(q_addr.size()), 0);

        // Asynchronous reset mid-simulation, no clock edge in between
        @(negedge clk); #2;
        rst = 1'b1; #1;
        check("arst_core_rst", 32'(core_rst), 1);
        check("arst_ready", 32'(ready), 0);
        check("arst_done", 32'(done), 0);
        check("arst_we", 32'(we), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("arst_ready_rel", 32'(ready), 1);
        @(negedge clk);

        // Glitch, then framing error, then realignment
        snap = n_wr;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        check("glitch_ferr", 32'(ferr), 0);
        send_byte(8'hAA, 1'b0);
        check("ferr_set", 32'(ferr), 1);
        send_word(32'h0000_0005);
        check("ferr_nwr", 32'(n_wr - snap), 1);
        check("ferr_pending", 32'(q_addr.size()), 0);

        // Overflow at the address-space boundary
        do_reset();
        snap = n_wr;
        for (int i = 0; i < 16; i++) send_word(rand_word());
        check("ovf_16_nwr", 32'(n_wr - snap), 16);
        check("ovf_16_flag", 32'(ovf), 0);
        send_word(rand_word());
        check("ovf_17_nwr", 32'(n_wr - snap), 16);
        check("ovf_17_flag", 32'(ovf), 32'(m_ovf));
        send_word(ENDW);
        check("ovf_done", 32'(done), 32'(m_done));

        // Bytes after DONE are ignored
        snap = n_wr;
        send_word(32'h0403_0201);
        check("post_done_nwr", 32'(n_wr - snap), 0);
        check("post_done_flag", 32'(done), 1);

        // Reset in the middle of a word, then reload
        do_reset();
        watch = 1;
        snap = n_wr;
        send_byte(8'($urandom()), 1'b1);
        send_byte(8'($urandom()), 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midword_core_rst", 32'(core_rst), 1);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        send_word(rand_word());
        check("reload_nwr", 32'(n_wr - snap), 1);
        check("reload_pending", 32'(q_addr.size()), 0);
        check("reload_core_held", 32'(rst_dropped), 0);
        check("reload_done", 32'(done), 0);
        check("final_ferr", 32'(ferr), 32'(m_ferr));
        watch = 0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
